alu_seq_core: RTL and testbench

- Parametrised sequential successor to the board-level 8-bit ALU datapath.
- Captures operands A and B from the switch bus on successive operation-button presses, then executes the selected operation.
- Single-cycle ops finish in one cycle; multiply and divide are multi-cycle iterative units.
- Holds result and status flags for the seven-segment and LED display logic. Sits between the board I/O (switches, buttons) and the display driver.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_iter.sv | 69 ++++++
 rtl/alu_seq_core.sv | 216 +++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the alu_seq_core slice.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_DIV0  = 3;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative unit: shift-add multiplier and restoring divider, one step per cycle for WIDTH cycles.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] low,
  output logic [WIDTH-1:0] high
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             active;
  logic [CW-1:0]    step;
  logic [WIDTH-1:0] cur_hi;
  logic [WIDTH-1:0] cur_lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // The start cycle performs the first step on the raw operands, so low/high
  // carry the finished result on the same cycle done is asserted.
  always_comb begin
    active = start | running;
    step   = start ? '0 : cnt;
    cur_hi = start ? '0 : hi_r;
    cur_lo = start ? a : lo_r;
    sum    = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, b} : '0);
    trial  = {cur_hi, cur_lo[WIDTH-1]};
    fits   = (trial >= {1'b0, b});
    diff   = fits ? (trial[WIDTH-1:0] - b) : trial[WIDTH-1:0];
    if (mode == MODE_DIV) begin
      high = diff;
      low  = {cur_lo[WIDTH-2:0], fits};
    end else begin
      high = sum[WIDTH:1];
      low  = {sum[0], cur_lo[WIDTH-1:1]};
    end
    done = active && (step == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      running <= 1'b0;
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else if (active) begin
      hi_r    <= high;
      lo_r    <= low;
      cnt     <= step + CW'(1);
      running <= !done;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Button-driven sequential ALU: capture A, capture B and opcode, execute, hold result for display.
// Optional button debounce filter enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       select,
  input  logic             do_in,
  output logic [WIDTH-1:0] led_a,
  output logic [WIDTH-1:0] led_b,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic [1:0]       state_o,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);

  if (WIDTH < 4 || WIDTH > 16 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("alu_seq_core: WIDTH must be 4..16 and DEBOUNCE_CYCLES at least 1");
  end

  state_t           state;
  logic [3:0]       op;
  logic             exec_first;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic             press;

  logic             is_div;
  logic             div0;
  logic             use_iter;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic             finish;

  logic [WIDTH-1:0]   res_y;
  logic [3:0]         res_flags;
  logic [WIDTH:0]     ext;
  logic [2*WIDTH-1:0] sh_wide;
  logic [SW-1:0]      sh;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1   <= do_in;
      sync2   <= sync1;
      level_q <= level;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DCW-1:0] db_cnt;
  logic           db_level;

  // The filtered level follows the synchronised level only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DCW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt   <= '0;
      db_level <= sync2;
    end else begin
      db_cnt <= db_cnt + DCW'(1);
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  assign press = level & ~level_q;

  assign is_div     = (op == OP_DIV) || (op == OP_MOD);
  assign div0       = is_div && (led_b == '0);
  assign use_iter   = (op == OP_MUL) || (is_div && !div0);
  assign iter_start = (state == EXEC) && exec_first && use_iter;
  assign finish     = (state == EXEC) && (use_iter ? iter_done : 1'b1);
  assign sh         = led_b[SW-1:0];
  assign state_o    = state;

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (iter_start),
    .mode  (is_div ? MODE_DIV : MODE_MUL),
    .a     (led_a),
    .b     (led_b),
    .done  (iter_done),
    .low   (iter_lo),
    .high  (iter_hi)
  );

  // Shifts use a double-width window so the carry is always the bit just past the result.
  always_comb begin
    res_y     = '0;
    res_flags = '0;
    ext       = '0;
    sh_wide   = '0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, led_a} + {1'b0, led_b};
        res_y = ext[WIDTH-1:0];
        res_flags[FLAG_CARRY] = ext[WIDTH];
        res_flags[FLAG_OVF] = (led_a[WIDTH-1] == led_b[WIDTH-1]) && (ext[WIDTH-1] != led_a[WIDTH-1]);
      end
      OP_SUB: begin
        ext = {1'b0, led_a} - {1'b0, led_b};
        res_y = ext[WIDTH-1:0];
        res_flags[FLAG_CARRY] = ext[WIDTH];
        res_flags[FLAG_OVF] = (led_a[WIDTH-1] != led_b[WIDTH-1]) && (ext[WIDTH-1] != led_a[WIDTH-1]);
      end
      OP_AND: res_y = led_a & led_b;
      OP_OR:  res_y = led_a | led_b;
      OP_XOR: res_y = led_a ^ led_b;
      OP_NOT: res_y = ~led_a;
      OP_SHL: begin
        sh_wide = {{WIDTH{1'b0}}, led_a} << sh;
        res_y = sh_wide[WIDTH-1:0];
        res_flags[FLAG_CARRY] = sh_wide[WIDTH];
      end
      OP_SHR: begin
        sh_wide = {led_a, {WIDTH{1'b0}}} >> sh;
        res_y = sh_wide[2*WIDTH-1:WIDTH];
        res_flags[FLAG_CARRY] = sh_wide[WIDTH-1];
      end
      OP_MUL: begin
        res_y = iter_lo;
        res_flags[FLAG_OVF] = |iter_hi;
      end
      OP_DIV, OP_MOD: begin
        if (div0) begin
          res_y = '1;
          res_flags[FLAG_DIV0] = 1'b1;
        end else begin
          res_y = (op == OP_DIV) ? iter_lo : iter_hi;
        end
      end
      OP_CMP: begin
        if (led_a == led_b)     res_y = '0;
        else if (led_a > led_b) res_y = WIDTH'(1);
        else                    res_y = '1;
      end
      default: ;
    endcase
    if (op <= OP_CMP) res_flags[FLAG_ZERO] = (res_y == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= LOAD_A;
      op         <= OP_ADD;
      exec_first <= 1'b0;
      led_a      <= '0;
      led_b      <= '0;
      y          <= '0;
      flags      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD_A: begin
          if (press) begin
            led_a <= data_in;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            led_b      <= data_in;
            op         <= select;
            busy       <= 1'b1;
            exec_first <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          exec_first <= 1'b0;
          if (finish) begin
            y     <= res_y;
            flags <= res_flags;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          if (press) state <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core at WIDTH=8: directed vector table, multi-cycle corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_alu_seq_core;

  localparam int W = 8;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    int op;
    int a;
    int b;
    int y;
    int f;
    int cyc;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         do_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [3:0]   select = '0;
  logic [W-1:0] led_a;
  logic [W-1:0] led_b;
  logic [W-1:0] y;
  logic [3:0]   flags;
  logic [1:0]   state_o;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  alu_seq_core #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .select  (select),
    .do_in   (do_in),
    .led_a   (led_a),
    .led_b   (led_b),
    .y       (y),
    .flags   (flags),
    .state_o (state_o),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timed out waiting for the DUT", name);
  endtask

  task automatic doReset();
    do_in = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pressButton(input int val, input int sel);
    logic [1:0] s0;
    bit moved;
    do_in = 1'b0;
    repeat (LAT + 2) tick();
    s0 = state_o;
    data_in = val[W-1:0];
    select = sel[3:0];
    do_in = 1'b1;
    moved = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      tick();
      if (state_o != s0) begin
        moved = 1;
        break;
      end
    end
    do_in = 1'b0;
    if (!moved) timeoutFail("press_state_change");
  endtask

  task automatic refModel(input int op, input int a, input int b,
                          output int yv, output int fv, output int cyc);
    int s, sa, sb, ss, sh, c, v, d, z;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sh = b % 8;
    yv = 0; c = 0; v = 0; d = 0; cyc = 1;
    case (op)
      0: begin s = a + b; yv = s % 256; c = int'(s > 255); ss = sa + sb; v = int'(ss > 127 || ss < -128); end
      1: begin yv = (a - b + 256) % 256; c = int'(a < b); ss = sa - sb; v = int'(ss > 127 || ss < -128); end
      2: yv = a & b;
      3: yv = a | b;
      4: yv = a ^ b;
      5: yv = (~a) & 255;
      6: begin yv = (a << sh) % 256; c = (sh == 0) ? 0 : ((a >> (8 - sh)) & 1); end
      7: begin yv = a >> sh; c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1); end
      8: begin s = a * b; yv = s % 256; v = int'(s > 255); cyc = 8; end
      9: if (b == 0) begin yv = 255; d = 1; end else begin yv = a / b; cyc = 8; end
      10: if (b == 0) begin yv = 255; d = 1; end else begin yv = a % b; cyc = 8; end
      11: yv = (a == b) ? 0 : ((a > b) ? 1 : 255);
      default: ;
    endcase
    z = int'(op <= 11 && yv == 0);
    fv = d * 8 + v * 4 + c * 2 + z;
  endtask

  // Full LOAD_A -> LOAD_B -> EXEC -> DONE -> LOAD_A pass; optionally pokes the
  // button and select during the first EXEC cycles.
  task automatic applyStimulus(input int op, input int a, input int b, input bit disturb,
                               output int yv, output int fv, output int cyc);
    bit got;
    pressButton(a, 0);
    checkOutput("state_load_b", state_o, 1);
    checkOutput("led_a_capture", led_a, a);
    pressButton(b, op);
    checkOutput("busy_in_exec", busy, 1);
    cyc = 1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (disturb) begin
        do_in = (cyc == 2 || cyc == 4);
        if (cyc <= 4) select = 4'($urandom_range(0, 15));
      end
      tick();
      if (done) begin
        got = 1;
        break;
      end
      cyc++;
    end
    do_in = 1'b0;
    if (!got) timeoutFail("done_pulse");
    yv = int'(y);
    fv = int'(flags);
    checkOutput("state_done", state_o, 3);
    checkOutput("busy_dropped", busy, 0);
    checkOutput("led_b_capture", led_b, b);
    tick();
    checkOutput("done_single_pulse", done, 0);
    checkOutput("state_holds_done", state_o, 3);
    pressButton(0, 0);
    checkOutput("state_back_load_a", state_o, 0);
  endtask

  initial begin
    vec_t vecs[16];
    int yv, fv, cyc, ey, ef, ec, op, a, b;

    vecs[0]  = '{0,  'h7F, 'h01, 'h80, 4, 1};
    vecs[1]  = '{8,  'h10, 'h10, 'h00, 5, 8};
    vecs[2]  = '{9,  200,  7,    28,   0, 8};
    vecs[3]  = '{10, 200,  7,    4,    0, 8};
    vecs[4]  = '{9,  200,  0,    'hFF, 8, 1};
    vecs[5]  = '{1,  'h05, 'h07, 'hFE, 2, 1};
    vecs[6]  = '{6,  'h81, 'h01, 'h02, 2, 1};
    vecs[7]  = '{7,  'h81, 'h01, 'h40, 2, 1};
    vecs[8]  = '{11, 3,    9,    'hFF, 0, 1};
    vecs[9]  = '{13, 'h12, 'h34, 'h00, 0, 1};
    vecs[10] = '{0,  'hFF, 'h01, 'h00, 3, 1};
    vecs[11] = '{10, 'h55, 0,    'hFF, 8, 1};
    vecs[12] = '{4,  'hAA, 'hAA, 'h00, 1, 1};
    vecs[13] = '{5,  'h0F, 'h00, 'hF0, 0, 1};
    vecs[14] = '{6,  'h81, 'h08, 'h81, 0, 1};
    vecs[15] = '{8,  'h0F, 'h11, 'hFF, 0, 8};

    reset = 1'b0;
    repeat (3) tick();
    checkOutput("reset_led_a", led_a, 0);
    checkOutput("reset_led_b", led_b, 0);
    checkOutput("reset_y", y, 0);
    checkOutput("reset_flags", flags, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_state", state_o, 0);
    reset = 1'b1;
    tick();

    repeat (LAT + 2) tick();
    data_in = 8'h5A;
    do_in = 1'b1;
    repeat (LAT - 1) tick();
    checkOutput("press_latency_early", state_o, 0);
    tick();
    checkOutput("press_latency_edge", state_o, 1);
    checkOutput("press_latency_led_a", led_a, 'h5A);
    data_in = 8'h33;
    repeat (50 - LAT) tick();
    checkOutput("held_single_capture", state_o, 1);
    checkOutput("held_led_a", led_a, 'h5A);
    doReset();

`ifdef ALU_SEQ_DEBOUNCE_EN
    repeat (8) tick();
    do_in = 1'b1;
    repeat (3) tick();
    do_in = 1'b0;
    repeat (20) tick();
    checkOutput("glitch_ignored", state_o, 0);
`endif

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 0, yv, fv, cyc);
      checkOutput($sformatf("vec%0d_y", i), yv, vecs[i].y);
      checkOutput($sformatf("vec%0d_flags", i), fv, vecs[i].f);
      checkOutput($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
    end

    applyStimulus(8, 'h0F, 'h11, 1, yv, fv, cyc);
    checkOutput("mul_disturbed_y", yv, 'hFF);
    checkOutput("mul_disturbed_flags", fv, 0);
    checkOutput("mul_disturbed_cycles", cyc, 8);

    pressButton(200, 0);
    pressButton(7, 9);
    repeat (3) tick();
    checkOutput("div_mid_busy", busy, 1);
    reset = 1'b0;
    tick();
    checkOutput("midreset_led_a", led_a, 0);
    checkOutput("midreset_led_b", led_b, 0);
    checkOutput("midreset_y", y, 0);
    checkOutput("midreset_flags", flags, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_state", state_o, 0);
    reset = 1'b1;
    applyStimulus(9, 200, 7, 0, yv, fv, cyc);
    checkOutput("div_after_reset_y", yv, 28);
    checkOutput("div_after_reset_flags", fv, 0);
    checkOutput("div_after_reset_cycles", cyc, 8);

    repeat (30) begin
      op = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      refModel(op, a, b, ey, ef, ec);
      applyStimulus(op, a, b, 0, yv, fv, cyc);
      checkOutput($sformatf("rand_op%0d_a%0h_b%0h_y", op, a, b), yv, ey);
      checkOutput($sformatf("rand_op%0d_a%0h_b%0h_flags", op, a, b), fv, ef);
      checkOutput($sformatf("rand_op%0d_a%0h_b%0h_cycles", op, a, b), cyc, ec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
